// File: rtl/serial_full_adder_if.sv
// Handshake/operand bundle for the bit-serial adder.
// SERIAL_FULL_ADDER_SUB_EN adds the per-operation sub select.
interface serial_full_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_FULL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_FULL_ADDER_SUB_EN
  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout
  );
  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_full_adder.sv
// Bit-serial adder, LSB first, one carry flop, start/busy/done.
// SERIAL_FULL_ADDER_SUB_EN adds a serial subtract mode (carry = borrow).
module serial_full_adder #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input logic               clk,
  input logic               rst,
  serial_full_adder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_FULL_ADDER_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic accept;
  logic last;
  logic bit_w;
  logic carry_w;

  assign accept = bus.start && (state_q != RUN);
  assign last   = (state_q == RUN) &&
                  (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    bit_w   = a_q[0] ^ b_q[0] ^ c_q;
    carry_w = (a_q[0] & b_q[0]) |
              (a_q[0] & c_q) |
              (b_q[0] & c_q);
`ifdef SERIAL_FULL_ADDER_SUB_EN
    if (sub_q) begin
      carry_w = (~a_q[0] & b_q[0]) |
                (~(a_q[0] ^ b_q[0]) & c_q);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    sum_d  = sum_q;
    c_d    = c_q;
    cout_d = cout_q;
    cnt_d  = cnt_q;
`ifdef SERIAL_FULL_ADDER_SUB_EN
    sub_d  = sub_q;
`endif
    unique case (1'b1)
      accept: begin
        a_d   = bus.a;
        b_d   = bus.b;
        c_d   = bus.cin;
        cnt_d = '0;
`ifdef SERIAL_FULL_ADDER_SUB_EN
        sub_d = bus.sub;
`endif
      end
      (state_q == RUN): begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        acc_d = {bit_w, acc_q[WIDTH-1:1]};
        c_d   = carry_w;
        cnt_d = cnt_q + CNT_W'(1);
        // Outputs only move here, so partial sums stay hidden.
        if (last) begin
          sum_d  = acc_d;
          cout_d = carry_w;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      sum_q  <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      cnt_q  <= '0;
`ifdef SERIAL_FULL_ADDER_SUB_EN
      sub_q  <= 1'b0;
`endif
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      sum_q  <= sum_d;
      c_q    <= c_d;
      cout_q <= cout_d;
      cnt_q  <= cnt_d;
`ifdef SERIAL_FULL_ADDER_SUB_EN
      sub_q  <= sub_d;
`endif
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_full_adder.sv
// Directed bench for serial_full_adder (WIDTH=8 and WIDTH=2).
// Define SERIAL_FULL_ADDER_SUB_EN to also cover subtract mode.
module tb_serial_full_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_full_adder_if #(.WIDTH(8)) bus ();
  serial_full_adder_if #(.WIDTH(2)) bus2 ();

  serial_full_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  serial_full_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] es;
    logic       ec;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic set_sub(input logic s);
`ifdef SERIAL_FULL_ADDER_SUB_EN
    bus.sub = s;
`else
    if (s) $display("sub ignored in add-only build");
`endif
  endtask

  task automatic run_op(input string nm,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic c,
                        input logic s,
                        input logic [7:0] es,
                        input logic ec);
    int n;
    logic bz_ok, hold_ok;
    logic [7:0] prev;
    prev = bus.sum;
    bus.a = a; bus.b = b; bus.cin = c;
    set_sub(s);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0; bz_ok = 1'b1; hold_ok = 1'b1;
    while (!bus.done && n < 40) begin
      if (!bus.busy) bz_ok = 1'b0;
      if (bus.sum !== prev) hold_ok = 1'b0;
      tick();
      n++;
    end
    check({nm, " latency"}, n, 8);
    check({nm, " busy"}, {31'd0, bz_ok}, 1);
    check({nm, " hold"}, {31'd0, hold_ok}, 1);
    check({nm, " busy@done"}, {31'd0, bus.busy}, 0);
    check({nm, " sum"}, {24'd0, bus.sum}, {24'd0, es});
    check({nm, " cout"}, {31'd0, bus.cout}, {31'd0, ec});
  endtask

  task automatic run2(input logic [1:0] a,
                      input logic [1:0] b,
                      input logic c,
                      output logic [1:0] s);
    int n;
    bus2.a = a; bus2.b = b; bus2.cin = c;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    n = 0;
    while (!bus2.done && n < 20) begin
      tick();
      n++;
    end
    check("w2 latency", n, 2);
    s = bus2.sum;
  endtask

  vec_t vecs[9];

  initial begin
    int n;
    logic ok;
    logic [1:0] s2;
    logic d, x, y, z;

    vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    bus.cin = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;
    bus2.cin = 1'b0;
`ifdef SERIAL_FULL_ADDER_SUB_EN
    bus2.sub = 1'b0;
`endif
    set_sub(1'b0);
    tick(); tick();
    check("rst busy", {31'd0, bus.busy}, 0);
    check("rst done", {31'd0, bus.done}, 0);
    check("rst sum", {24'd0, bus.sum}, 0);
    check("rst cout", {31'd0, bus.cout}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a,
             vecs[i].b, vecs[i].cin, 1'b0,
             vecs[i].es, vecs[i].ec);
      tick();
      check($sformatf("vec%0d idle hold", i),
            {24'd0, bus.sum}, {24'd0, vecs[i].es});
    end

    // start re-pulsed mid-run must be ignored
    bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.a = 8'hAA; bus.b = 8'h55; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 3;
    while (!bus.done && n < 40) begin tick(); n++; end
    check("ignore latency", n, 8);
    check("ignore sum", {24'd0, bus.sum}, 32'h30);
    check("ignore cout", {31'd0, bus.cout}, 0);
    tick();

    // start held high through DONE chains a new op
    bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b0;
    bus.start = 1'b1;
    tick();
    n = 0;
    while (!bus.done && n < 40) begin tick(); n++; end
    check("chain1 latency", n, 8);
    check("chain1 sum", {24'd0, bus.sum}, 32'h03);
    bus.a = 8'h03; bus.b = 8'h04;
    tick();
    bus.start = 1'b0;
    check("chain2 busy", {31'd0, bus.busy}, 1);
    n = 0;
    while (!bus.done && n < 40) begin tick(); n++; end
    check("chain2 latency", n, 8);
    check("chain2 sum", {24'd0, bus.sum}, 32'h07);
    tick();

    // reset in the middle of a run
    bus.a = 8'h33; bus.b = 8'h44; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-rst busy", {31'd0, bus.busy}, 0);
    check("mid-rst done", {31'd0, bus.done}, 0);
    check("mid-rst sum", {24'd0, bus.sum}, 0);
    check("mid-rst cout", {31'd0, bus.cout}, 0);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.done || bus.busy) ok = 1'b0;
      tick();
    end
    check("mid-rst quiet", {31'd0, ok}, 1);
    run_op("fresh", 8'h33, 8'h44, 1'b1, 1'b0,
           8'h78, 1'b0);
    tick();

    // reconstruct X from full-subtractor D, Y, Z
    for (int i = 0; i < 8; i++) begin
      x = i[2]; y = i[1]; z = i[0];
      d = x ^ y ^ z;
      run2({1'b0, d}, {1'b0, y}, z, s2);
      check($sformatf("inv x%0d y%0d z%0d", x, y, z),
            {31'd0, s2[0]}, {31'd0, x});
      tick();
    end

`ifdef SERIAL_FULL_ADDER_SUB_EN
    run_op("sub1", 8'h10, 8'h01, 1'b0, 1'b1,
           8'h0F, 1'b0);
    tick();
    run_op("sub2", 8'h00, 8'h01, 1'b0, 1'b1,
           8'hFF, 1'b1);
    tick();
    run_op("sub3", 8'h05, 8'h03, 1'b1, 1'b1,
           8'h01, 1'b0);
    tick();
    run_op("sub0add", 8'h3C, 8'h05, 1'b0, 1'b0,
           8'h41, 1'b0);
    tick();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
